// File: rtl/dmem_access_fsm.sv
// rtl/dmem_access_fsm.sv - single-port data-memory sequencer between the load/store RS and the data cache
module dmem_access_fsm #(
   parameter int LOAD_RS_DEPTH = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     move_flush,
   input  logic                     dmem_r_rqst,
   input  logic [LOAD_RS_DEPTH-1:0] load_rs_idx_rqst,
   input  logic [31:0]              arbiter_load_rs_addr,
   input  logic [3:0]               arbiter_load_rs_rmask,
   input  logic                     dmem_w_rqst,
   input  logic [31:0]              store_addr,
   input  logic [3:0]               store_wmask,
   input  logic [31:0]              store_wdata,
   output logic                     load_rs_pop,
   output logic [LOAD_RS_DEPTH-1:0] load_rs_idx_executing,
   output logic [31:0]              load_rdata,
   output logic                     store_rs_pop,
   output logic [31:0]              dmem_addr,
   output logic [3:0]               dmem_rmask,
   output logic [3:0]               dmem_wmask,
   output logic [31:0]              dmem_wdata,
   input  logic [31:0]              dmem_rdata,
   input  logic                     dmem_resp,
   output logic                     dmem_busy
);

   localparam logic [1:0] IDLE        = 2'd0;
   localparam logic [1:0] LOAD_WAIT   = 2'd1;
   localparam logic [1:0] STORE_WAIT  = 2'd2;
   localparam logic [1:0] FLUSH_DRAIN = 2'd3;

   logic [1:0]               state;
   logic [31:0]              addr_q;
   logic [3:0]               rmask_q;
   logic [3:0]               wmask_q;
   logic [31:0]              wdata_q;
   logic [LOAD_RS_DEPTH-1:0] idx_q;

   // Any wait state ends on the cache response; a response seen in IDLE is stray.
   logic access_done;
   assign access_done = (state != IDLE) && dmem_resp;

   // State and latched request; registers clear on return to IDLE so the cache sees zeros there.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         addr_q  <= '0;
         rmask_q <= '0;
         wmask_q <= '0;
         wdata_q <= '0;
         idx_q   <= '0;
      end else if (access_done) begin
         state   <= IDLE;
         addr_q  <= '0;
         rmask_q <= '0;
         wmask_q <= '0;
         wdata_q <= '0;
         idx_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Committed stores win; a flushed load is simply not taken this cycle.
               if (dmem_w_rqst) begin
                  state   <= STORE_WAIT;
                  addr_q  <= store_addr;
                  rmask_q <= '0;
                  wmask_q <= store_wmask;
                  wdata_q <= store_wdata;
                  idx_q   <= '0;
               end else if (dmem_r_rqst && !move_flush) begin
                  state   <= LOAD_WAIT;
                  addr_q  <= arbiter_load_rs_addr;
                  rmask_q <= arbiter_load_rs_rmask;
                  wmask_q <= '0;
                  wdata_q <= '0;
                  idx_q   <= load_rs_idx_rqst;
               end
            end
            LOAD_WAIT: begin
               // The load is dead but the cache access must still be drained.
               if (move_flush) begin
                  state <= FLUSH_DRAIN;
               end
            end
            default: begin
               // STORE_WAIT and FLUSH_DRAIN only leave on the response.
               state <= state;
            end
         endcase
      end
   end

   // Completion pulses and result return; result fields are zero unless a load pops.
   always_comb begin
      load_rs_pop           = (state == LOAD_WAIT) && dmem_resp && !move_flush;
      store_rs_pop          = (state == STORE_WAIT) && dmem_resp;
      load_rs_idx_executing = load_rs_pop ? idx_q : '0;
      load_rdata            = load_rs_pop ? dmem_rdata : '0;
   end

   // Cache-side outputs come only from the latched request, word-aligned address.
   always_comb begin
      dmem_addr  = addr_q & 32'hFFFF_FFFC;
      dmem_rmask = rmask_q;
      dmem_wmask = wmask_q;
      dmem_wdata = wdata_q;
      dmem_busy  = (state != IDLE);
   end

endmodule

// File: tb/tb_dmem_access_fsm.sv
// tb/tb_dmem_access_fsm.sv - self-checking bench for dmem_access_fsm
module tb_dmem_access_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic        move_flush;
   logic        dmem_r_rqst;
   logic [2:0]  load_rs_idx_rqst;
   logic [31:0] arbiter_load_rs_addr;
   logic [3:0]  arbiter_load_rs_rmask;
   logic        dmem_w_rqst;
   logic [31:0] store_addr;
   logic [3:0]  store_wmask;
   logic [31:0] store_wdata;
   logic        load_rs_pop;
   logic [2:0]  load_rs_idx_executing;
   logic [31:0] load_rdata;
   logic        store_rs_pop;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_rmask;
   logic [3:0]  dmem_wmask;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_resp;
   logic        dmem_busy;

   int checks = 0;
   int errors = 0;

   dmem_access_fsm #(.LOAD_RS_DEPTH(3)) dut (
      .clk(clk), .rst(rst), .move_flush(move_flush),
      .dmem_r_rqst(dmem_r_rqst), .load_rs_idx_rqst(load_rs_idx_rqst),
      .arbiter_load_rs_addr(arbiter_load_rs_addr), .arbiter_load_rs_rmask(arbiter_load_rs_rmask),
      .dmem_w_rqst(dmem_w_rqst), .store_addr(store_addr), .store_wmask(store_wmask),
      .store_wdata(store_wdata), .load_rs_pop(load_rs_pop),
      .load_rs_idx_executing(load_rs_idx_executing), .load_rdata(load_rdata),
      .store_rs_pop(store_rs_pop), .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask),
      .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
      .dmem_resp(dmem_resp), .dmem_busy(dmem_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r;
      logic [2:0]  idx;
      logic [31:0] laddr;
      logic [3:0]  rmask;
      logic        w;
      logic [31:0] saddr;
      logic [3:0]  wmask;
      logic [31:0] wdata;
      logic        flush;
      logic        resp;
      logic [31:0] rdata;
      logic        e_lpop;
      logic [2:0]  e_idx;
      logic [31:0] e_ldata;
      logic        e_spop;
      logic [31:0] e_addr;
      logic [3:0]  e_rmask;
      logic [3:0]  e_wmask;
      logic [31:0] e_wdata;
      logic        e_busy;
   } vec_t;

   vec_t tbl[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string t, input logic lp, input logic [2:0] ix, input logic [31:0] ld,
                          input logic sp, input logic [31:0] a, input logic [3:0] rm,
                          input logic [3:0] wm, input logic [31:0] wd, input logic b);
      check({t, ".load_rs_pop"}, 32'(load_rs_pop), 32'(lp));
      check({t, ".idx_exec"}, 32'(load_rs_idx_executing), 32'(ix));
      check({t, ".load_rdata"}, load_rdata, ld);
      check({t, ".store_rs_pop"}, 32'(store_rs_pop), 32'(sp));
      check({t, ".dmem_addr"}, dmem_addr, a);
      check({t, ".dmem_rmask"}, 32'(dmem_rmask), 32'(rm));
      check({t, ".dmem_wmask"}, 32'(dmem_wmask), 32'(wm));
      check({t, ".dmem_wdata"}, dmem_wdata, wd);
      check({t, ".dmem_busy"}, 32'(dmem_busy), 32'(b));
   endtask

   task automatic idle_in();
      move_flush = 0; dmem_r_rqst = 0; load_rs_idx_rqst = 0; arbiter_load_rs_addr = 0;
      arbiter_load_rs_rmask = 0; dmem_w_rqst = 0; store_addr = 0; store_wmask = 0;
      store_wdata = 0; dmem_rdata = 0; dmem_resp = 0;
   endtask

   task automatic nxt();
      @(negedge clk);
      idle_in();
   endtask

   task automatic give_load(input logic [2:0] ix, input logic [31:0] a, input logic [3:0] m);
      dmem_r_rqst = 1; load_rs_idx_rqst = ix; arbiter_load_rs_addr = a; arbiter_load_rs_rmask = m;
   endtask

   task automatic give_store(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
      dmem_w_rqst = 1; store_addr = a; store_wmask = m; store_wdata = d;
   endtask

   // reference model: the transaction currently owned by the sequencer
   bit          m_busy, m_store, m_dead;
   logic [31:0] m_addr, m_data;
   logic [3:0]  m_mask;
   logic [2:0]  m_idx;

   initial begin
      idle_in();
      rst = 0;
      // r,idx,laddr,rmask, w,saddr,wmask,wdata, flush,resp,rdata, lpop,idx,ldata,spop, addr,rmask,wmask,wdata,busy
      tbl[0]  = '{1,5,32'h1006,4'hC, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0};
      tbl[1]  = '{0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0, 32'h1004,4'hC,0,0,1};
      tbl[2]  = '{0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0, 32'h1004,4'hC,0,0,1};
      tbl[3]  = '{0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0, 32'h1004,4'hC,0,0,1};
      tbl[4]  = '{0,0,0,0, 0,0,0,0, 0,1,32'hAABBCCDD, 1,5,32'hAABBCCDD,0, 32'h1004,4'hC,0,0,1};
      tbl[5]  = '{0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0};
      tbl[6]  = '{1,2,32'h40,4'h3, 1,32'h20,4'hF,32'h12345678, 0,0,0, 0,0,0,0, 0,0,0,0,0};
      tbl[7]  = '{1,2,32'h40,4'h3, 1,32'h20,4'hF,32'h12345678, 0,0,0, 0,0,0,0, 32'h20,0,4'hF,32'h12345678,1};
      tbl[8]  = '{1,2,32'h40,4'h3, 1,32'h20,4'hF,32'h12345678, 0,1,32'h99, 0,0,0,1, 32'h20,0,4'hF,32'h12345678,1};
      tbl[9]  = '{1,2,32'h40,4'h3, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0};
      tbl[10] = '{1,2,32'h40,4'h3, 0,0,0,0, 0,0,0, 0,0,0,0, 32'h40,4'h3,0,0,1};
      tbl[11] = '{1,2,32'h40,4'h3, 0,0,0,0, 0,1,32'h55, 1,2,32'h55,0, 32'h40,4'h3,0,0,1};
      tbl[12] = '{0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0};

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      dmem_resp = 1; dmem_r_rqst = 1;
      #1;
      chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      nxt();
      rst = 1;

      // table: single load and store priority
      for (int i = 0; i < 13; i++) begin
         nxt();
         dmem_r_rqst = tbl[i].r; load_rs_idx_rqst = tbl[i].idx;
         arbiter_load_rs_addr = tbl[i].laddr; arbiter_load_rs_rmask = tbl[i].rmask;
         dmem_w_rqst = tbl[i].w; store_addr = tbl[i].saddr; store_wmask = tbl[i].wmask;
         store_wdata = tbl[i].wdata; move_flush = tbl[i].flush; dmem_resp = tbl[i].resp;
         dmem_rdata = tbl[i].rdata;
         #1;
         chk_all($sformatf("tbl%0d", i), tbl[i].e_lpop, tbl[i].e_idx, tbl[i].e_ldata, tbl[i].e_spop,
                 tbl[i].e_addr, tbl[i].e_rmask, tbl[i].e_wmask, tbl[i].e_wdata, tbl[i].e_busy);
      end

      // flush mid-load: flush at cycle 2 (held two cycles), resp at cycle 5
      nxt(); give_load(3'd1, 32'h2000, 4'hF); #1;
      nxt(); #1; chk_all("fl.c1", 0, 0, 0, 0, 32'h2000, 4'hF, 0, 0, 1);
      nxt(); move_flush = 1; #1; chk_all("fl.c2", 0, 0, 0, 0, 32'h2000, 4'hF, 0, 0, 1);
      nxt(); move_flush = 1; #1; chk_all("fl.c3", 0, 0, 0, 0, 32'h2000, 4'hF, 0, 0, 1);
      nxt(); #1; chk_all("fl.c4", 0, 0, 0, 0, 32'h2000, 4'hF, 0, 0, 1);
      nxt(); dmem_resp = 1; dmem_rdata = 32'hDEADBEEF; #1;
      chk_all("fl.c5", 0, 0, 0, 0, 32'h2000, 4'hF, 0, 0, 1);
      nxt(); #1; chk_all("fl.c6", 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // flush coinciding with resp in LOAD_WAIT
      nxt(); give_load(3'd3, 32'h3001, 4'h2); #1;
      nxt(); move_flush = 1; dmem_resp = 1; dmem_rdata = 32'h77; #1;
      chk_all("flr.c1", 0, 0, 0, 0, 32'h3000, 4'h2, 0, 0, 1);
      nxt(); #1; chk_all("flr.c2", 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // flush in IDLE blocks a load but not a store; flush during a store has no effect
      nxt(); give_load(3'd7, 32'h10, 4'h1); move_flush = 1; #1;
      nxt(); #1; check("flidle.load_blocked", 32'(dmem_busy), 0);
      nxt(); give_store(32'h44, 4'h3, 32'hCAFE); move_flush = 1; #1;
      nxt(); move_flush = 1; #1; chk_all("fls.c1", 0, 0, 0, 0, 32'h44, 0, 4'h3, 32'hCAFE, 1);
      nxt(); move_flush = 1; dmem_resp = 1; #1; chk_all("fls.c2", 0, 0, 0, 1, 32'h44, 0, 4'h3, 32'hCAFE, 1);
      nxt(); #1; chk_all("fls.c3", 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // async reset mid-access, then a fresh load
      nxt(); give_load(3'd6, 32'h5008, 4'h2); #1;
      nxt(); #1; chk_all("ar.wait", 0, 0, 0, 0, 32'h5008, 4'h2, 0, 0, 1);
      #2; dmem_resp = 1; dmem_rdata = 32'h1234; rst = 0; #1;
      chk_all("ar.async", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      nxt(); rst = 1; give_load(3'd4, 32'h600C, 4'h8); #1;
      nxt(); #1; chk_all("ar.c1", 0, 0, 0, 0, 32'h600C, 4'h8, 0, 0, 1);
      nxt(); dmem_resp = 1; dmem_rdata = 32'h11; #1;
      chk_all("ar.c2", 1, 3'd4, 32'h11, 0, 32'h600C, 4'h8, 0, 0, 1);
      nxt(); #1;

      // randomized traffic against the transaction-level model
      m_busy = 0; m_store = 0; m_dead = 0; m_addr = 0; m_data = 0; m_mask = 0; m_idx = 0;
      for (int c = 0; c < 3000; c++) begin
         logic e_lpop, e_spop;
         nxt();
         dmem_r_rqst = ($urandom % 2) == 0;
         load_rs_idx_rqst = 3'($urandom);
         arbiter_load_rs_addr = $urandom;
         arbiter_load_rs_rmask = 4'($urandom);
         dmem_w_rqst = ($urandom % 4) == 0;
         store_addr = $urandom;
         store_wmask = 4'($urandom);
         store_wdata = $urandom;
         move_flush = ($urandom % 8) == 0;
         dmem_resp = ($urandom % 3) == 0;
         dmem_rdata = $urandom;
         #1;
         e_lpop = m_busy && !m_store && !m_dead && dmem_resp && !move_flush;
         e_spop = m_busy && m_store && dmem_resp;
         chk_all($sformatf("rnd%0d", c), e_lpop, e_lpop ? m_idx : 3'd0, e_lpop ? dmem_rdata : 32'd0, e_spop,
                 m_busy ? (m_addr & 32'hFFFF_FFFC) : 32'd0,
                 (m_busy && !m_store) ? m_mask : 4'd0,
                 (m_busy && m_store) ? m_mask : 4'd0,
                 (m_busy && m_store) ? m_data : 32'd0, m_busy);
         if (!m_busy) begin
            if (dmem_w_rqst) begin
               m_busy = 1; m_store = 1; m_dead = 0;
               m_addr = store_addr; m_mask = store_wmask; m_data = store_wdata; m_idx = 0;
            end else if (dmem_r_rqst && !move_flush) begin
               m_busy = 1; m_store = 0; m_dead = 0;
               m_addr = arbiter_load_rs_addr; m_mask = arbiter_load_rs_rmask; m_data = 0;
               m_idx = load_rs_idx_rqst;
            end
         end else if (dmem_resp) begin
            m_busy = 0;
         end else if (!m_store && move_flush) begin
            m_dead = 1;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_access_fsm.md
# dmem_access_fsm

Single-port data-memory sequencer between the load/store reservation stations and the data cache. It picks one ready memory operation per access, with committed stores taking priority over loads. It holds the request to the cache until `dmem_resp`, then returns the result by pulsing `load_rs_pop` (with the entry index and the raw read data) or `store_rs_pop`. Loads in flight during a pipeline flush are drained and their responses dropped. Committed stores always complete.

## Interface
- `LOAD_RS_DEPTH`, default 3: log2 of load RS entries; width of the entry index.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (asserted when 0).
- `move_flush`  in  1  pipeline flush; kills in-flight and newly presented loads.
- `dmem_r_rqst`  in  1  load RS has a ready entry.
- `load_rs_idx_rqst`  in  LOAD_RS_DEPTH  index of the requesting load entry.
- `arbiter_load_rs_addr`  in  32  byte address of the load.
- `arbiter_load_rs_rmask`  in  4  lane-aligned read mask, already shifted by address.
- `dmem_w_rqst`  in  1  store RS head is committed and ready to write.
- `store_addr`  in  32  byte address of the store.
- `store_wmask`  in  4  lane-aligned write mask.
- `store_wdata`  in  32  lane-aligned write data.
- `load_rs_pop`  out  1  one-cycle pulse: load completed; the load RS frees the entry and drives the CDB.
- `load_rs_idx_executing`  out  LOAD_RS_DEPTH  index of the completing load entry.
- `load_rdata`  out  32  raw cache word for the completing load.
- `store_rs_pop`  out  1  one-cycle pulse: store completed; the store RS advances its head.
- `dmem_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `dmem_rmask`  out  4  read mask to the cache.
- `dmem_wmask`  out  4  write mask to the cache.
- `dmem_wdata`  out  32  write data to the cache.
- `dmem_rdata`  in  32  cache read data; valid when `dmem_resp` is high.
- `dmem_resp`  in  1  cache access done.
- `dmem_busy`  out  1  FSM is not in IDLE.

## Operation
- States:
  - IDLE
  - LOAD_WAIT
  - STORE_WAIT
  - FLUSH_DRAIN
- Latched registers, all cleared on reset and on return to IDLE:
  - `addr_q[31:0]`, `rmask_q`, `wmask_q`, `wdata_q`, `idx_q`
- IDLE:
  - If `dmem_w_rqst`: latch store fields (`rmask_q=0`), go to STORE_WAIT.
  - Else if `dmem_r_rqst && !move_flush`: latch load fields and index (`wmask_q=0`, `wdata_q=0`), go to LOAD_WAIT.
  - Else stay in IDLE.
- LOAD_WAIT:
  - `dmem_resp && !move_flush`: `load_rs_pop=1`, `load_rs_idx_executing=idx_q`, `load_rdata=dmem_rdata` (combinational), go to IDLE.
  - `dmem_resp && move_flush`: no pop, go to IDLE.
  - `!dmem_resp && move_flush`: go to FLUSH_DRAIN.
  - Request inputs are ignored while waiting.
- FLUSH_DRAIN:
  - Hold the dmem outputs; `move_flush` is ignored.
  - On `dmem_resp`: no pop, go to IDLE.
- STORE_WAIT:
  - On `dmem_resp`: `store_rs_pop=1`, go to IDLE.
  - `move_flush` has no effect in this state.
- Outputs:
  - `dmem_addr`, `dmem_rmask`, `dmem_wmask` and `dmem_wdata` are driven only from the latched registers, never combinationally from inputs.
  - They are held stable from the first wait cycle through the `dmem_resp` cycle inclusive.
  - They are 0 in IDLE.
- Exclusivity:
  - `load_rs_pop` and `store_rs_pop` are never high in the same cycle.
  - `dmem_rmask` and `dmem_wmask` are never both nonzero.
- `load_rs_idx_executing` and `load_rdata` are 0 whenever `load_rs_pop` is 0.
- Data:
  - Masks and wdata pass through unmodified.
  - The byte offset is dropped only from `dmem_addr`; lane selection and sign extension belong to the load RS.

## Timing
- Reset (`rst=0`, asynchronous):
  - State goes to IDLE and all latched registers clear.
  - Every output is 0 immediately, including mid-access; the abandoned cache response is not tracked.
- Latency:
  - A request sampled in IDLE at cycle 0 drives the cache from cycle 1.
  - A `dmem_resp` at cycle k gives pop at cycle k.
  - The FSM is in IDLE at k+1; the next request is sampled at k+1 and reaches the cache at k+2.
  - Minimum: 2 cycles per access and 1 idle cycle between accesses.
- Priority: a store wins over a load presented in the same IDLE cycle; the load stays asserted by the load RS and is taken at the next IDLE.
- `move_flush` in IDLE:
  - A load is not accepted that cycle.
  - A store is still accepted.
- Multi-cycle flush: only the first flush cycle of an in-flight load matters; the load ends in FLUSH_DRAIN with no pop.
- A `dmem_resp` that arrives while in IDLE is ignored.

## Test plan
- Single load: `dmem_r_rqst=1`, idx=5, addr=0x1006, rmask=4'b1100 at cycle 0; `dmem_resp` at cycle 4 with rdata=0xAABBCCDD.
  - Expect `dmem_addr=0x1004` and `dmem_rmask=4'b1100` during cycles 1–4.
  - Expect `load_rs_pop=1`, idx=5 and `load_rdata=0xAABBCCDD` at cycle 4 only.
  - Expect all outputs 0 at cycle 5.
- Store priority: load (idx=2) and store (addr=0x20, wmask=4'b1111, wdata=0x12345678) presented together.
  - The store is issued first; `store_rs_pop` pulses on its resp.
  - The load is issued at the following IDLE; `load_rs_pop` pulses with idx=2 on its resp.
- Flush mid-load: load issued; `move_flush` at cycle 2; `dmem_resp` at cycle 5.
  - dmem outputs are held through cycle 5.
  - No `load_rs_pop` is asserted.
  - The FSM is in IDLE at cycle 6.
- Flush coinciding with resp in LOAD_WAIT: no pop, next state IDLE.
- Flush during a store: `move_flush` while in STORE_WAIT.
  - The store still completes.
  - `store_rs_pop=1` on resp.
- Async reset mid-access: drive `rst=0` between clock edges while in LOAD_WAIT.
  - All outputs go to 0 before the next edge.
  - After `rst=1`, a new load is accepted normally.
